// File: rtl/sc_scratchpad_pkg.sv
// Shared definitions for the scratchpad arbiter: FSM state encoding,
// address-mux select values, the hard-wired zero register and default widths.
package sc_scratchpad_pkg;

    localparam int DEF_SCRATCHPAD_DIRECTION = 5;
    localparam int DEF_MIR_DIRECTION        = 6;
    localparam int DEF_BUS                  = 32;
    localparam int DEF_MAX_UDP_BURST        = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_UDP       = 3'd0;
    localparam state_t S_HOST_ADDR = 3'd1;
    localparam state_t S_HOST_CAPT = 3'd2;
    localparam state_t S_HOST_ACK  = 3'd3;
    localparam state_t S_RELEASE   = 3'd4;

    localparam logic SP_SELECT_MIR  = 1'b1;
    localparam logic SP_SELECT_HOST = 1'b0;

    localparam int REG_ZERO_ADDR = 0;

endpackage

// File: rtl/sc_arb_starve_counter.sv
// Saturating count of cycles a pending host request has been denied.
// Ports: clk_i/rst_i (async high), inc_i, clr_i (wins over inc), sat_o.
module sc_arb_starve_counter
    import sc_scratchpad_pkg::*;
#(
    parameter int MAX_COUNT = DEF_MAX_UDP_BURST
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == CW'(MAX_COUNT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_scratchpad_arbiter.sv
// Shares the scratchpad port between the microcoded datapath (default owner)
// and a host/debug port. A pending host access takes a free cycle, or is
// forced in after MAX_UDP_BURST denied cycles; the host owns exactly one
// cycle (S_HOST_ADDR), read data is captured one cycle later, then Ack.
// Ports:
//   clock/reset  : SC_SCRATCHPAD_ARBITER_CLOCK_50, SC_SCRATCHPAD_ARBITER_RESET_InHigh
//   datapath     : uDP_Req/Addr/WrEn/WrData in, uDP_Stall_Out
//   host         : Host_Req/Wr/Addr/WrData in, Host_Ack_Out, Host_RdData_OutBus
//   scratchpad   : SP_Select/Addr/WrEn/WrData out, SP_RdData_InBus
module sc_scratchpad_arbiter
    import sc_scratchpad_pkg::*;
#(
    parameter int DATAWIDTH_SCRATCHPAD_DIRECTION = DEF_SCRATCHPAD_DIRECTION,
    parameter int DATAWIDTH_MIR_DIRECTION        = DEF_MIR_DIRECTION,
    parameter int DATAWIDTH_BUS                  = DEF_BUS,
    parameter int MAX_UDP_BURST                  = DEF_MAX_UDP_BURST
) (
    input  logic                                      SC_SCRATCHPAD_ARBITER_CLOCK_50,
    input  logic                                      SC_SCRATCHPAD_ARBITER_RESET_InHigh,
    input  logic                                      uDP_Req_In,
    input  logic [DATAWIDTH_MIR_DIRECTION-1:0]        uDP_Addr_InBus,
    input  logic                                      uDP_WrEn_In,
    input  logic [DATAWIDTH_BUS-1:0]                  uDP_WrData_InBus,
    output logic                                      uDP_Stall_Out,
    input  logic                                      Host_Req_In,
    input  logic                                      Host_Wr_In,
    input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] Host_Addr_InBus,
    input  logic [DATAWIDTH_BUS-1:0]                  Host_WrData_InBus,
    output logic                                      Host_Ack_Out,
    output logic [DATAWIDTH_BUS-1:0]                  Host_RdData_OutBus,
    output logic                                      SP_Select_Out,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]        SP_Addr_OutBus,
    output logic                                      SP_WrEn_Out,
    output logic [DATAWIDTH_BUS-1:0]                  SP_WrData_OutBus,
    input  logic [DATAWIDTH_BUS-1:0]                  SP_RdData_InBus
);

    localparam int SW  = DATAWIDTH_SCRATCHPAD_DIRECTION;
    localparam int MW  = DATAWIDTH_MIR_DIRECTION;
    localparam int BW  = DATAWIDTH_BUS;

    state_t          state_q, state_d;
    logic [BW-1:0]   rd_q, rd_d;
    logic            in_udp;
    logic            grant;
    logic            starve_inc;
    logic            starve_clr;
    logic            starve_sat;
    logic            host_r0;

    assign in_udp = (state_q == S_UDP);

    // Host wins when the datapath is idle or has starved it long enough.
    assign grant = in_udp && Host_Req_In && (!uDP_Req_In || starve_sat);

    assign starve_inc = in_udp && Host_Req_In && uDP_Req_In;
    assign starve_clr = grant || (in_udp && !Host_Req_In);

    assign host_r0 = (Host_Addr_InBus == SW'(REG_ZERO_ADDR));

    sc_arb_starve_counter #(
        .MAX_COUNT (MAX_UDP_BURST)
    ) u_starve (
        .clk_i (SC_SCRATCHPAD_ARBITER_CLOCK_50),
        .rst_i (SC_SCRATCHPAD_ARBITER_RESET_InHigh),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    always_ff @(posedge SC_SCRATCHPAD_ARBITER_CLOCK_50
                or posedge SC_SCRATCHPAD_ARBITER_RESET_InHigh) begin
        if (SC_SCRATCHPAD_ARBITER_RESET_InHigh) begin
            state_q <= S_UDP;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_UDP:       if (grant) state_d = S_HOST_ADDR;
            S_HOST_ADDR: state_d = S_HOST_CAPT;
            S_HOST_CAPT: state_d = S_HOST_ACK;
            // A request still high after Ack parks in S_RELEASE so it is
            // never serviced twice.
            S_HOST_ACK:  state_d = Host_Req_In ? S_RELEASE : S_UDP;
            S_RELEASE:   if (!Host_Req_In) state_d = S_UDP;
            default:     state_d = S_UDP;
        endcase
    end

    // Synchronous scratchpad: data for the S_HOST_ADDR address is on
    // SP_RdData_InBus during S_HOST_CAPT.
    always_comb begin
        rd_d = rd_q;
        if (state_q == S_HOST_CAPT && !Host_Wr_In) begin
            rd_d = SP_RdData_InBus;
        end
    end

    always_comb begin
        SP_Select_Out    = SP_SELECT_MIR;
        SP_Addr_OutBus   = uDP_Addr_InBus;
        SP_WrEn_Out      = uDP_Req_In && uDP_WrEn_In;
        SP_WrData_OutBus = uDP_WrData_InBus;
        uDP_Stall_Out    = 1'b0;
        Host_Ack_Out     = (state_q == S_HOST_ACK);
        if (state_q == S_HOST_ADDR) begin
            SP_Select_Out    = SP_SELECT_HOST;
            SP_Addr_OutBus   = {{(MW-SW){1'b0}}, Host_Addr_InBus};
            SP_WrEn_Out      = Host_Wr_In && !host_r0;
            SP_WrData_OutBus = Host_WrData_InBus;
            uDP_Stall_Out    = uDP_Req_In;
        end
        // No scratchpad writes of any kind while held in reset.
        if (SC_SCRATCHPAD_ARBITER_RESET_InHigh) begin
            SP_WrEn_Out = 1'b0;
        end
    end

    assign Host_RdData_OutBus = rd_q;

endmodule

// File: tb/tb_sc_scratchpad_arbiter.sv
// Self-checking bench for sc_scratchpad_arbiter with a scratchpad memory
// model and a transaction-level reference of host grant/ack timing.
module tb_sc_scratchpad_arbiter;

    localparam int SW   = 5;
    localparam int MW   = 6;
    localparam int BW   = 32;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uDP_Req_In = 1'b0;
    logic [MW-1:0] uDP_Addr_InBus = '0;
    logic          uDP_WrEn_In = 1'b0;
    logic [BW-1:0] uDP_WrData_InBus = '0;
    logic          uDP_Stall_Out;
    logic          Host_Req_In = 1'b0;
    logic          Host_Wr_In = 1'b0;
    logic [SW-1:0] Host_Addr_InBus = '0;
    logic [BW-1:0] Host_WrData_InBus = '0;
    logic          Host_Ack_Out;
    logic [BW-1:0] Host_RdData_OutBus;
    logic          SP_Select_Out;
    logic [MW-1:0] SP_Addr_OutBus;
    logic          SP_WrEn_Out;
    logic [BW-1:0] SP_WrData_OutBus;
    logic [BW-1:0] SP_RdData_InBus;

    int vectors = 0;
    int miscompares = 0;

    logic [BW-1:0] sp_mem [64] = '{default: '0};
    logic [BW-1:0] ref_mem [32] = '{default: '0};
    logic [BW-1:0] exp_rd = '0;

    always #10 clk = ~clk;

    sc_scratchpad_arbiter dut (
        .SC_SCRATCHPAD_ARBITER_CLOCK_50     (clk),
        .SC_SCRATCHPAD_ARBITER_RESET_InHigh (rst),
        .uDP_Req_In                         (uDP_Req_In),
        .uDP_Addr_InBus                     (uDP_Addr_InBus),
        .uDP_WrEn_In                        (uDP_WrEn_In),
        .uDP_WrData_InBus                   (uDP_WrData_InBus),
        .uDP_Stall_Out                      (uDP_Stall_Out),
        .Host_Req_In                        (Host_Req_In),
        .Host_Wr_In                         (Host_Wr_In),
        .Host_Addr_InBus                    (Host_Addr_InBus),
        .Host_WrData_InBus                  (Host_WrData_InBus),
        .Host_Ack_Out                       (Host_Ack_Out),
        .Host_RdData_OutBus                 (Host_RdData_OutBus),
        .SP_Select_Out                      (SP_Select_Out),
        .SP_Addr_OutBus                     (SP_Addr_OutBus),
        .SP_WrEn_Out                        (SP_WrEn_Out),
        .SP_WrData_OutBus                   (SP_WrData_OutBus),
        .SP_RdData_InBus                    (SP_RdData_InBus)
    );

    // Scratchpad with one-cycle synchronous read.
    always @(posedge clk) begin
        if (SP_WrEn_Out) sp_mem[SP_Addr_OutBus] <= SP_WrData_OutBus;
        SP_RdData_InBus <= sp_mem[SP_Addr_OutBus];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One host transaction. mode: 0 datapath idle, 1 datapath always
    // requesting, 2 random datapath requests. hold: cycles Req stays high
    // after the Ack cycle.
    task automatic host_op(input logic wr, input logic [SW-1:0] a,
                           input logic [BW-1:0] d, input int mode, input int hold);
        int denied = 0;
        int grant_at = -1;
        int ack_at = -1;
        int acks = 0;
        int stalls = 0;
        logic req;
        logic udp;
        logic [MW-1:0] ua;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            req = (ack_at < 0) || (c <= ack_at + hold);
            case (mode)
                0: udp = 1'b0;
                1: udp = 1'b1;
                default: udp = 1'($urandom_range(0, 1));
            endcase
            ua = MW'($urandom);
            Host_Req_In = req;
            Host_Wr_In = wr;
            Host_Addr_InBus = a;
            Host_WrData_InBus = d;
            uDP_Req_In = udp;
            uDP_WrEn_In = 1'b0;
            uDP_Addr_InBus = ua;
            uDP_WrData_InBus = $urandom;
            if (grant_at < 0 && req) begin
                if (!udp || denied == MAXB) grant_at = c;
                else denied++;
            end
            #2;
            if (grant_at >= 0 && c == grant_at + 1) begin
                chk("host_sel", 32'(SP_Select_Out), 32'(0));
                chk("host_addr", 32'(SP_Addr_OutBus), 32'(a));
                chk("host_wren", 32'(SP_WrEn_Out), 32'(wr && (a != 5'd0)));
                chk("host_wdata", SP_WrData_OutBus, d);
                chk("host_stall", 32'(uDP_Stall_Out), 32'(udp));
                if (wr && (a != 5'd0)) ref_mem[a] = d;
            end else begin
                chk("udp_sel", 32'(SP_Select_Out), 32'(1));
                chk("udp_addr", 32'(SP_Addr_OutBus), 32'(ua));
                chk("udp_wren", 32'(SP_WrEn_Out), 32'(0));
                chk("udp_stall", 32'(uDP_Stall_Out), 32'(0));
            end
            if (grant_at >= 0 && c == grant_at + 3) begin
                ack_at = c;
                if (!wr) exp_rd = ref_mem[a];
            end
            chk("ack", 32'(Host_Ack_Out), 32'(ack_at == c));
            chk("rddata", Host_RdData_OutBus, exp_rd);
            if (Host_Ack_Out) acks++;
            if (uDP_Stall_Out) stalls++;
            if (ack_at >= 0 && c >= ack_at + hold + 2) break;
        end
        chk("acked", 32'(ack_at >= 0), 32'(1));
        chk("ack_count", 32'(acks), 32'(1));
        if (mode == 1) begin
            chk("starve_grant", 32'(grant_at), 32'(MAXB));
            chk("stall_count", 32'(stalls), 32'(1));
        end
        if (mode == 0) chk("idle_latency", 32'(ack_at), 32'(3));
        Host_Req_In = 1'b0;
    endtask

    initial begin
        logic          udp;
        logic          we;
        logic [MW-1:0] ua;
        logic [BW-1:0] ud;

        // Reset with an active datapath write request.
        uDP_Req_In = 1'b1;
        uDP_WrEn_In = 1'b1;
        uDP_Addr_InBus = 6'd7;
        @(negedge clk);
        #2;
        chk("rst_sel", 32'(SP_Select_Out), 32'(1));
        chk("rst_wren", 32'(SP_WrEn_Out), 32'(0));
        chk("rst_stall", 32'(uDP_Stall_Out), 32'(0));
        chk("rst_ack", 32'(Host_Ack_Out), 32'(0));
        chk("rst_rddata", Host_RdData_OutBus, 32'(0));
        @(negedge clk);
        rst = 1'b0;
        uDP_Req_In = 1'b0;
        uDP_WrEn_In = 1'b0;
        @(negedge clk);
        #2;
        chk("idle_sel", 32'(SP_Select_Out), 32'(1));
        chk("idle_ack", 32'(Host_Ack_Out), 32'(0));

        host_op(1'b1, 5'd5, 32'hDEADBEEF, 0, 0);
        host_op(1'b0, 5'd5, 32'h0, 0, 0);
        chk("r5_readback", Host_RdData_OutBus, 32'hDEADBEEF);
        host_op(1'b0, 5'd5, 32'h0, 1, 0);
        host_op(1'b1, 5'd0, 32'h12345678, 0, 0);
        host_op(1'b0, 5'd5, 32'h0, 0, 4);
        host_op(1'b1, 5'd9, 32'hA5A5_0F0F, 0, 0);
        host_op(1'b0, 5'd9, 32'h0, 0, 0);

        // Datapath pass-through, including unfiltered writes.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            udp = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ua = MW'($urandom);
            ud = $urandom;
            Host_Req_In = 1'b0;
            uDP_Req_In = udp;
            uDP_WrEn_In = we;
            uDP_Addr_InBus = ua;
            uDP_WrData_InBus = ud;
            #2;
            chk("dp_sel", 32'(SP_Select_Out), 32'(1));
            chk("dp_addr", 32'(SP_Addr_OutBus), 32'(ua));
            chk("dp_wren", 32'(SP_WrEn_Out), 32'(udp & we));
            chk("dp_wdata", SP_WrData_OutBus, ud);
            chk("dp_stall", 32'(uDP_Stall_Out), 32'(0));
            if (udp && we && ua < 6'd32) ref_mem[ua[4:0]] = ud;
        end
        @(negedge clk);
        uDP_Req_In = 1'b0;
        uDP_WrEn_In = 1'b0;

        for (int i = 0; i < 24; i++) begin
            host_op(1'($urandom_range(0, 1)), SW'($urandom), $urandom,
                    2, $urandom_range(0, 3));
        end

        // Make sure RdData is non-zero before checking reset clears it.
        host_op(1'b1, 5'd3, 32'hCAFE_F00D, 0, 0);
        host_op(1'b0, 5'd3, 32'h0, 0, 0);

        // Reset during S_HOST_CAPT of a read.
        @(negedge clk);
        Host_Req_In = 1'b1;
        Host_Wr_In = 1'b0;
        Host_Addr_InBus = 5'd5;
        uDP_Req_In = 1'b0;
        @(negedge clk);
        #2;
        chk("abort_addr_sel", 32'(SP_Select_Out), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        uDP_Req_In = 1'b1;
        uDP_WrEn_In = 1'b1;
        #2;
        chk("abort_sel", 32'(SP_Select_Out), 32'(1));
        chk("abort_wren", 32'(SP_WrEn_Out), 32'(0));
        chk("abort_stall", 32'(uDP_Stall_Out), 32'(0));
        chk("abort_ack", 32'(Host_Ack_Out), 32'(0));
        chk("abort_rddata", Host_RdData_OutBus, 32'(0));
        exp_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        Host_Req_In = 1'b0;
        uDP_Req_In = 1'b0;
        uDP_WrEn_In = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk("post_abort_ack", 32'(Host_Ack_Out), 32'(0));
            chk("post_abort_sel", 32'(SP_Select_Out), 32'(1));
        end
        host_op(1'b0, 5'd5, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
